// File: rtl/mouse_ps2_tracker.sv
// mouse_ps2_tracker
// Receives the raw PS/2 mouse serial stream and assembles 3-byte movement
// packets. Each packet is added to a clamped screen cursor position, and the
// button levels are updated at the same time. Everything runs in the clk domain.
module mouse_ps2_tracker #(
  parameter int X_MAX   = 799,
  parameter int Y_MAX   = 599,
  parameter int X_INIT  = 400,
  parameter int Y_INIT  = 300,
  parameter int TIMEOUT = 65000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [11:0] mouse_x,
  output logic [11:0] mouse_y,
  output logic        left_mouse,
  output logic        right_mouse,
  output logic        packet_valid,
  output logic        frame_err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic signed [12:0] X_MAX_S = 13'(X_MAX);
  localparam logic signed [12:0] Y_MAX_S = 13'(Y_MAX);
  localparam logic [3:0] STOP_IDX = 4'd10;

  typedef enum logic [1:0] {
    BYTE0,
    BYTE1,
    BYTE2
  } pktState_e;

  // Input conditioning
  logic [1:0] clkSync_q;
  logic [1:0] dataSync_q;
  logic       clkDly_q;
  logic       strobe;
  logic       dataBit;

  // Frame receiver
  logic [3:0]    bitCnt_q, bitCnt_d;
  logic [9:0]    frame_q, frame_d;
  logic [TW-1:0] toCnt_q, toCnt_d;
  logic [7:0]    byte_q, byte_d;
  logic          byteValid_q, byteValid_d;
  logic          frameErr_q, frameErr_d;

  // Packet assembly
  pktState_e state_q, state_d;
  logic [7:0] b0_q, b0_d;
  logic [7:0] dx_q, dx_d;
  logic       apply;

  // Cursor and buttons
  logic [11:0] xPos_q, yPos_q;
  logic        left_q, right_q;
  logic        packetValid_q;

  logic signed [12:0] dxExt, dyExt;
  logic signed [12:0] sumX, sumY;
  logic [11:0]        clampX, clampY;

  // Double-flop both PS/2 lines. Keep one more copy of the clock so its falling edge can be detected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clkSync_q  <= 2'b11;
      dataSync_q <= 2'b11;
      clkDly_q   <= 1'b1;
    end else begin
      clkSync_q  <= {clkSync_q[0], ps2_clk};
      dataSync_q <= {dataSync_q[0], ps2_data};
      clkDly_q   <= clkSync_q[1];
    end
  end

  assign strobe  = clkDly_q & ~clkSync_q[1];
  assign dataBit = dataSync_q[1];

  // Receiver next state. On each falling-edge strobe, collect start, data and parity by index.
  // The stop-bit strobe judges the whole frame. A frame that goes quiet mid-way is aborted by the idle counter.
  always_comb begin
    bitCnt_d    = bitCnt_q;
    frame_d     = frame_q;
    toCnt_d     = toCnt_q;
    byte_d      = byte_q;
    byteValid_d = 1'b0;
    frameErr_d  = 1'b0;
    if (strobe) begin
      toCnt_d = '0;
      if (bitCnt_q == STOP_IDX) begin
        bitCnt_d = '0;
        if (!frame_q[0] && (^frame_q[9:1]) && dataBit) begin
          byte_d      = frame_q[8:1];
          byteValid_d = 1'b1;
        end else begin
          frameErr_d = 1'b1;
        end
      end else begin
        frame_d[bitCnt_q] = dataBit;
        bitCnt_d          = bitCnt_q + 4'd1;
      end
    end else if (bitCnt_q != 4'd0) begin
      if (toCnt_q == TO_LAST) begin
        bitCnt_d   = '0;
        toCnt_d    = '0;
        frameErr_d = 1'b1;
      end else begin
        toCnt_d = toCnt_q + 1'b1;
      end
    end
  end

  // Receiver state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitCnt_q    <= '0;
      frame_q     <= '0;
      toCnt_q     <= '0;
      byte_q      <= '0;
      byteValid_q <= 1'b0;
      frameErr_q  <= 1'b0;
    end else begin
      bitCnt_q    <= bitCnt_d;
      frame_q     <= frame_d;
      toCnt_q     <= toCnt_d;
      byte_q      <= byte_d;
      byteValid_q <= byteValid_d;
      frameErr_q  <= frameErr_d;
    end
  end

  // Packet FSM next state. A rejected frame drops the partial packet.
  // In BYTE0, a byte with bit3 clear cannot be a header and is skipped so the stream can resync.
  always_comb begin
    state_d = state_q;
    b0_d    = b0_q;
    dx_d    = dx_q;
    apply   = 1'b0;
    if (frameErr_q) begin
      state_d = BYTE0;
    end else if (byteValid_q) begin
      case (state_q)
        BYTE0: begin
          if (byte_q[3]) begin
            b0_d    = byte_q;
            state_d = BYTE1;
          end
        end
        BYTE1: begin
          dx_d    = byte_q;
          state_d = BYTE2;
        end
        BYTE2: begin
          apply   = 1'b1;
          state_d = BYTE0;
        end
        default: state_d = BYTE0;
      endcase
    end
  end

  // Packet FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BYTE0;
      b0_q    <= '0;
      dx_q    <= '0;
    end else begin
      state_q <= state_d;
      b0_q    <= b0_d;
      dx_q    <= dx_d;
    end
  end

  // Build the 9-bit deltas from byte 0's sign bits, then add them to the position and clamp to the screen.
  // Screen Y grows downward, so the PS/2 dy is subtracted. dy is the byte arriving in this very cycle.
  always_comb begin
    dxExt = {{4{b0_q[4]}}, b0_q[4], dx_q};
    dyExt = {{4{b0_q[5]}}, b0_q[5], byte_q};
    sumX  = $signed({1'b0, xPos_q}) + dxExt;
    sumY  = $signed({1'b0, yPos_q}) - dyExt;
    if (sumX < 13'sd0) begin
      clampX = '0;
    end else if (sumX > X_MAX_S) begin
      clampX = X_MAX_S[11:0];
    end else begin
      clampX = sumX[11:0];
    end
    if (sumY < 13'sd0) begin
      clampY = '0;
    end else if (sumY > Y_MAX_S) begin
      clampY = Y_MAX_S[11:0];
    end else begin
      clampY = sumY[11:0];
    end
  end

  // Cursor and button registers change only when a full packet is applied.
  // An axis whose overflow flag is set keeps its previous value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xPos_q        <= 12'(X_INIT);
      yPos_q        <= 12'(Y_INIT);
      left_q        <= 1'b0;
      right_q       <= 1'b0;
      packetValid_q <= 1'b0;
    end else begin
      packetValid_q <= apply;
      if (apply) begin
        if (!b0_q[6]) xPos_q <= clampX;
        if (!b0_q[7]) yPos_q <= clampY;
        left_q  <= b0_q[0];
        right_q <= b0_q[1];
      end
    end
  end

  assign mouse_x      = xPos_q;
  assign mouse_y      = yPos_q;
  assign left_mouse   = left_q;
  assign right_mouse  = right_q;
  assign packet_valid = packetValid_q;
  assign frame_err    = frameErr_q;

endmodule

// File: doc/mouse_ps2_tracker.md
# mouse_ps2_tracker

Receives the raw PS/2 mouse serial stream, assembles standard 3-byte movement packets and accumulates them into a clamped screen cursor position plus button levels. It produces the `mouse_x`, `mouse_y` and `left_mouse` signals consumed by the button hit-test and cursor-drawing logic. It sits between the board PS/2 pins and the game/UI layer in the pixel-clock domain.

## Interface

Reset is asynchronous and active-low.

Parameters:
- `X_MAX`, default 799: largest legal `mouse_x`.
- `Y_MAX`, default 599: largest legal `mouse_y`.
- `X_INIT`, default 400: `mouse_x` after reset.
- `Y_INIT`, default 300: `mouse_y` after reset.
- `TIMEOUT`, default 65000: idle `clk` cycles allowed inside a frame before it is aborted.

Ports:
- `clk`  in  1  system clock; all logic runs on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `ps2_clk`  in  1  raw PS/2 clock; asynchronous to `clk`.
- `ps2_data`  in  1  raw PS/2 data; asynchronous to `clk`.
- `mouse_x`  out  12  cursor X, range 0..`X_MAX`.
- `mouse_y`  out  12  cursor Y, range 0..`Y_MAX`; 0 is the top of the screen.
- `left_mouse`  out  1  left button level.
- `right_mouse`  out  1  right button level.
- `packet_valid`  out  1  one-cycle pulse when a complete packet has been applied.
- `frame_err`  out  1  one-cycle pulse on a rejected byte frame.

## Operation

**Input conditioning and edge detect**
- `ps2_clk` and `ps2_data` each pass through a 2-FF synchronizer.
- A third register on the synchronized clock gives a falling-edge strobe, active one cycle per falling edge.

**Frame receiver**
- Bit counter runs 0..10.
- On each strobe the receiver samples `ps2_data` in this order: start (must be 0), 8 data bits LSB first, odd parity, stop (must be 1).
- A byte is accepted only if start = 0, parity is odd over data+parity, and stop = 1.
- Otherwise: `frame_err` pulses, the byte is discarded, and the packet index returns to 0.
- Timeout: if the bit counter is non-zero and no strobe arrives for `TIMEOUT` cycles:
  - the partial frame is discarded;
  - the bit counter goes to 0;
  - the packet index goes to 0;
  - `frame_err` pulses.

**Packet FSM**
- States: BYTE0, BYTE1, BYTE2.
- BYTE0: an accepted byte with bit3 = 1 is stored and the FSM moves to BYTE1. An accepted byte with bit3 = 0 is silently dropped (resync) and the FSM stays in BYTE0.
- BYTE1: store dx and move to BYTE2.
- BYTE2: store dy, apply the packet, return to BYTE0.

**Byte 0 fields**
- bit0 = left, bit1 = right.
- bit4 = X sign, bit5 = Y sign.
- bit6 = X overflow, bit7 = Y overflow.

**Packet application**
- Deltas are 9-bit two's complement `{sign, byte}`, sign-extended to 13 bits.
- new_x = x + dx; new_y = y − dy (PS/2 up-positive maps to screen down-positive).
- Each result is clamped: below 0 → 0; above max → max.
- An axis whose overflow bit is set keeps its old position. Buttons still update.
- `left_mouse` and `right_mouse` update only on packet application.

**Reset values**
- `mouse_x` = `X_INIT`, `mouse_y` = `Y_INIT`.
- `left_mouse`, `right_mouse`, `packet_valid`, `frame_err` = 0.
- FSM in BYTE0, bit counter 0, timeout counter 0.

## Timing

- Strobe latency: a `ps2_clk` falling edge produces its strobe 3 cycles later.
- Stop bit sampled on strobe cycle N:
  - byte register and accept/reject decision are valid in cycle N+1;
  - `frame_err` is high in cycle N+1 only.
- Third byte accepted in cycle N+1:
  - `mouse_x`, `mouse_y`, `left_mouse`, `right_mouse` take new values in cycle N+2;
  - `packet_valid` is high in cycle N+2 only.
- Outputs are stable between packets. No output changes mid-packet.
- `rst_n` asserted mid-frame or mid-packet discards everything immediately. The first packet after release must start with a fresh start bit.
- Timeout counter resets on every strobe. The abort fires on the cycle the count reaches `TIMEOUT`.

## Test plan

1. **Reset.** Hold `rst_n` = 0, toggle `ps2_clk` → `mouse_x` = 400, `mouse_y` = 300, buttons 0, no pulses.
2. **Basic packet.** Frames 0x09, 0x0A, 0x05 → `left_mouse` = 1, `mouse_x` = 410, `mouse_y` = 295. `packet_valid` pulses exactly once, 2 cycles after the last stop strobe.
3. **Clamping.**
   - Two packets 0x18, 0x00, 0x00 (dx = −256) → `mouse_x` = 144, then 0.
   - Packets 0x28, 0x00, 0x80 (dy = −128) → `mouse_y` rises by 128 per packet and saturates at 599.
   - Overflow packet 0x48, 0x50, 0x00 → X unchanged.
4. **Parity error.** Parity error in byte 1 → `frame_err` pulse, no `packet_valid`. The next correct packet 0x0A, 0x01, 0x01 applies cleanly: `right_mouse` = 1, x+1, y−1.
5. **Resync.** Byte 0x00 (bit3 = 0) before a valid packet → dropped without `frame_err`. The following packet applies normally.
6. **Timeout and mid-frame reset.**
   - Stop after 5 bits for `TIMEOUT` + 10 cycles → one `frame_err`, and the next full packet is decoded correctly.
   - Assert `rst_n` mid-byte → outputs return to the reset values.
